// File: rtl/fifo_byte_packer.sv
// rtl/fifo_byte_packer.sv - drains a show-ahead byte FIFO and packs bytes MSB-first into BYTE_NUM-byte words
module fifo_byte_packer #(
    parameter int BYTE_NUM = 4,
    parameter int WORD_W   = 8 * BYTE_NUM
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fifo_empty,
    input  logic [7:0]        iv_fifo_rdata,
    output logic              o_fifo_rdreq,
    input  logic              i_flush,
    output logic [WORD_W-1:0] ov_word,
    output logic              o_word_valid,
    input  logic              i_word_ready,
    output logic [15:0]       ov_word_cnt
);

    typedef enum logic {S_COLLECT, S_OUT} state_t;

    localparam logic [2:0] LAST_IDX = 3'(BYTE_NUM - 1);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        rv_idx;
    logic [WORD_W-1:0] rv_shift;
    logic              xfer;
    logic              last_byte;

    // A pop in S_OUT is only allowed in the transfer cycle, so the held word never has a follower waiting.
    assign o_fifo_rdreq = i_rst_n && !i_fifo_empty && !i_flush &&
                          ((state == S_COLLECT) || i_word_ready);
    assign xfer         = o_word_valid && i_word_ready;
    assign last_byte    = o_fifo_rdreq && (state == S_COLLECT) && (rv_idx == LAST_IDX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_COLLECT: if (last_byte) state_nxt = S_OUT;
            S_OUT:     if (xfer)      state_nxt = S_COLLECT;
            default:   state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rv_idx       <= 3'd0;
            rv_shift     <= '0;
            ov_word      <= '0;
            o_word_valid <= 1'b0;
            ov_word_cnt  <= 16'd0;
        end else begin
            if (xfer) begin
                o_word_valid <= 1'b0;
                ov_word_cnt  <= ov_word_cnt + 16'd1;
            end
            // Stale lanes need no clearing: each is rewritten before the next word completes.
            if (i_flush) begin
                rv_idx <= 3'd0;
            end else if (o_fifo_rdreq) begin
                rv_shift[(BYTE_NUM - 1 - int'(rv_idx)) * 8 +: 8] <= iv_fifo_rdata;
                if (last_byte) begin
                    ov_word      <= {rv_shift[WORD_W-1:8], iv_fifo_rdata};
                    o_word_valid <= 1'b1;
                    rv_idx       <= 3'd0;
                end else begin
                    rv_idx <= rv_idx + 3'd1;
                end
            end
        end
    end

endmodule
